// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: drives the PC register, issues one imem request at a time,
// buffers the returned instruction for decode and applies branch/jump redirects.
module fetch_sequencer #(
   parameter int                    ADDR_WIDTH   = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] pc_cur,
   output logic                  pc_enable,
   output logic [ADDR_WIDTH-1:0] pc_next,
   output logic                  imem_req_valid,
   input  logic                  imem_req_ready,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic                  imem_rsp_valid,
   input  logic [31:0]           imem_rsp_data,
   output logic                  if_valid,
   output logic [31:0]           if_instr,
   output logic [ADDR_WIDTH-1:0] if_pc,
   input  logic                  id_ready,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_target
);

   typedef enum logic [2:0] {BOOT, REQ, WAIT, VALID, FLUSH} state_t;

   state_t                state, state_next;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [ADDR_WIDTH-1:0] target;
   logic [ADDR_WIDTH-1:0] pc_incr;
   logic                  capture;

   assign target    = redirect_target & ~ADDR_WIDTH'(3);
   assign pc_incr   = pc_cur + ADDR_WIDTH'(4);
   assign imem_addr = pc_cur;

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_next     = state;
      pc_enable      = 1'b0;
      pc_next        = pc_incr;
      imem_req_valid = 1'b0;
      capture        = 1'b0;
      case (state)
         BOOT: begin
            pc_enable  = 1'b1;
            pc_next    = RESET_VECTOR;
            state_next = REQ;
         end
         REQ: begin
            imem_req_valid = !redirect_valid;
            if (redirect_valid) begin
               pc_enable = 1'b1;
               pc_next   = target;
            end else if (imem_req_ready) begin
               state_next = WAIT;
            end
         end
         WAIT: begin
            // A response colliding with a redirect is already stale: drop it and refetch.
            if (redirect_valid) begin
               pc_enable  = 1'b1;
               pc_next    = target;
               state_next = imem_rsp_valid ? REQ : FLUSH;
            end else if (imem_rsp_valid) begin
               capture    = 1'b1;
               state_next = VALID;
            end
         end
         VALID: begin
            if (redirect_valid) begin
               pc_enable  = 1'b1;
               pc_next    = target;
               state_next = REQ;
            end else if (id_ready) begin
               pc_enable  = 1'b1;
               state_next = REQ;
            end
         end
         FLUSH: begin
            if (redirect_valid) begin
               pc_enable = 1'b1;
               pc_next   = target;
            end
            if (imem_rsp_valid) state_next = REQ;
         end
         default: state_next = BOOT;
      endcase
      // Keep the PC and memory quiet for the whole time reset is held.
      if (rst) begin
         pc_enable      = 1'b0;
         imem_req_valid = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= BOOT;
         req_addr <= '0;
         if_valid <= 1'b0;
         if_instr <= '0;
         if_pc    <= '0;
      end else begin
         state    <= state_next;
         if_valid <= (state_next == VALID);
         if (imem_req_valid && imem_req_ready) req_addr <= pc_cur;
         if (capture) begin
            if_instr <= imem_rsp_data;
            if_pc    <= req_addr;
         end
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized and directed bench for fetch_sequencer against a transaction-level fetch model
// (architectural PC, outstanding/stale/buffered flags) plus a latency-randomized memory.
module tb_fetch_sequencer;

   localparam logic [31:0] RV = 32'h100;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_cur;
   logic        pc_enable;
   logic [31:0] pc_next;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        id_ready;
   logic        redirect_valid;
   logic [31:0] redirect_target;

   fetch_sequencer #(.ADDR_WIDTH(32), .RESET_VECTOR(RV)) dut (
      .clk(clk), .rst(rst), .pc_cur(pc_cur), .pc_enable(pc_enable), .pc_next(pc_next),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int n_req    = 0;
   int lat_min  = 1;
   int lat_max  = 1;

   // Reference model: architectural PC plus what the fetch unit is doing with memory.
   logic [31:0] mdl_pc;
   logic        mdl_boot, mdl_outst, mdl_stale, mdl_full;
   logic        prev_hold, prev_stall;
   logic [31:0] prev_instr, prev_pc, prev_addr;
   logic [31:0] last_req, last_fire_next;
   pend_t       mem_q[$];
   int          fire_cyc[$];
   logic [31:0] fire_pc[$];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h1234_5678;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      redirect_valid = 1'b0; redirect_target = '0;
      id_ready = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
      mem_q.delete();
      pc_cur = $urandom & ~32'h3;
      @(posedge clk); #1;
      check("rst_if_valid", if_valid, 0);
      check("rst_if_instr", if_instr, 0);
      check("rst_if_pc", if_pc, 0);
      check("rst_req_valid", imem_req_valid, 0);
      check("rst_pc_enable", pc_enable, 0);
      rst = 1'b0;
      mdl_boot = 1'b1; mdl_outst = 1'b0; mdl_stale = 1'b0; mdl_full = 1'b0;
      prev_hold = 1'b0; prev_stall = 1'b0;
   endtask

   // One clock cycle: drive inputs, check outputs against the model, advance model and PC.
   task automatic step(input logic rv, input logic [31:0] rt, input logic idr, input logic rdy);
      logic        rsp, hs, fire, en_exp, en_s;
      logic [31:0] a, nxt_exp, nxt_s;
      pend_t       p;
      rsp = 1'b0; a = '0;
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         rsp = 1'b1; a = mem_q[0].addr; mem_q.delete(0);
      end
      redirect_valid = rv; redirect_target = rt; id_ready = idr; imem_req_ready = rdy;
      imem_rsp_valid = rsp; imem_rsp_data = rsp ? mem_word(a) : $urandom;
      #1;
      fire   = mdl_full && idr && !rv;
      en_exp = mdl_boot || rv || fire;
      if (mdl_boot)  nxt_exp = RV;
      else if (rv)   nxt_exp = rt & ~32'h3;
      else           nxt_exp = mdl_pc + 32'd4;
      check("req_valid", imem_req_valid, !mdl_boot && !mdl_outst && !mdl_full && !rv);
      check("if_valid", if_valid, mdl_full);
      check("pc_enable", pc_enable, en_exp);
      if (en_exp) check("pc_next", pc_next, nxt_exp);
      if (fire) begin
         check("if_pc", if_pc, mdl_pc);
         check("if_instr", if_instr, mem_word(mdl_pc));
         fire_cyc.push_back(cyc); fire_pc.push_back(if_pc);
         last_fire_next = pc_next;
      end
      if (prev_hold) begin
         check("hold_instr", if_instr, prev_instr);
         check("hold_pc", if_pc, prev_pc);
      end
      if (prev_stall && imem_req_valid) check("addr_stable", imem_addr, prev_addr);
      hs = imem_req_valid && rdy;
      if (hs) begin
         check("req_addr", imem_addr, mdl_pc);
         p.addr = imem_addr;
         p.due  = cyc + int'($urandom_range(lat_max, lat_min));
         mem_q.push_back(p);
         last_req = imem_addr; n_req++;
      end
      prev_hold  = if_valid && !idr && !rv;
      prev_instr = if_instr; prev_pc = if_pc;
      prev_stall = imem_req_valid && !rdy; prev_addr = imem_addr;
      en_s = pc_enable; nxt_s = pc_next;
      if (rsp) begin
         if (mdl_outst && !mdl_stale && !rv) mdl_full = 1'b1;
         mdl_outst = 1'b0; mdl_stale = 1'b0;
      end else if (rv && mdl_outst) begin
         mdl_stale = 1'b1;
      end
      if (rv || fire) mdl_full = 1'b0;
      if (hs) mdl_outst = 1'b1;
      if (en_exp) mdl_pc = nxt_exp;
      mdl_boot = 1'b0;
      @(posedge clk); #1;
      if (en_s) pc_cur = nxt_s;
      cyc++;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] hold_pc;
      int          req0, fires0;
      logic        rv;
      logic [31:0] rt;

      do_reset();

      // Best-case streaming from the reset vector.
      fire_cyc.delete(); fire_pc.delete();
      repeat (12) step(1'b0, '0, 1'b1, 1'b1);
      check("tp_count", fire_pc.size() >= 3, 1);
      if (fire_pc.size() >= 3) begin
         for (int i = 0; i < 3; i++) check("tp_pc", fire_pc[i], RV + 32'(4 * i));
         for (int i = 1; i < 3; i++) check("tp_gap", 32'(fire_cyc[i] - fire_cyc[i-1]), 3);
      end

      // Decode stalls for 5 cycles with an instruction buffered.
      for (int k = 0; k < 10 && !mdl_full; k++) step(1'b0, '0, 1'b0, 1'b1);
      check("stall_reach", if_valid, 1);
      hold_pc = pc_cur; req0 = n_req;
      repeat (5) step(1'b0, '0, 1'b0, 1'b1);
      check("stall_pc", pc_cur, hold_pc);
      check("stall_req", 32'(n_req), 32'(req0));
      step(1'b0, '0, 1'b1, 1'b1);

      // Redirect in WAIT, stale response arrives 3 cycles later.
      lat_min = 4; lat_max = 4;
      for (int k = 0; k < 10 && !mdl_outst; k++) step(1'b0, '0, 1'b1, 1'b1);
      step(1'b1, 32'h2002, 1'b1, 1'b1);
      check("redir_pc", pc_cur, 32'h2000);
      req0 = n_req;
      for (int k = 0; k < 12 && n_req == req0; k++) step(1'b0, '0, 1'b1, 1'b1);
      check("redir_req", last_req, 32'h2000);

      // Redirect and response in the same WAIT cycle.
      lat_min = 1; lat_max = 1;
      for (int k = 0; k < 10 && !mdl_outst; k++) step(1'b0, '0, 1'b0, 1'b1);
      step(1'b1, 32'h3000, 1'b1, 1'b1);
      check("wr_pc", pc_cur, 32'h3000);
      check("wr_drop", if_valid, 0);
      req0 = n_req;
      for (int k = 0; k < 12 && n_req == req0; k++) step(1'b0, '0, 1'b0, 1'b1);
      check("wr_req", last_req, 32'h3000);

      // Redirect and id_ready in the same VALID cycle.
      for (int k = 0; k < 10 && !mdl_full; k++) step(1'b0, '0, 1'b0, 1'b1);
      step(1'b1, 32'h3400, 1'b1, 1'b1);
      check("vr_pc", pc_cur, 32'h3400);
      check("vr_drop", if_valid, 0);
      req0 = n_req;
      for (int k = 0; k < 12 && n_req == req0; k++) step(1'b0, '0, 1'b1, 1'b1);
      check("vr_req", last_req, 32'h3400);

      // Two redirects while flushing.
      lat_min = 5; lat_max = 5;
      for (int k = 0; k < 10 && !mdl_outst; k++) step(1'b0, '0, 1'b1, 1'b1);
      step(1'b1, 32'h40, 1'b1, 1'b1);
      step(1'b1, 32'h80, 1'b1, 1'b1);
      check("fl_pc", pc_cur, 32'h80);
      req0 = n_req; fires0 = fire_pc.size();
      for (int k = 0; k < 12 && n_req == req0; k++) step(1'b0, '0, 1'b1, 1'b1);
      check("fl_req", last_req, 32'h80);
      check("fl_no_fire", 32'(fire_pc.size()), 32'(fires0));

      // PC wrap on an accepted instruction at the top of memory.
      lat_min = 1; lat_max = 1;
      step(1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1);
      fires0 = fire_pc.size();
      for (int k = 0; k < 12 && fire_pc.size() == fires0; k++) step(1'b0, '0, 1'b1, 1'b1);
      check("wrap_next", last_fire_next, 32'h0);
      check("wrap_pc", pc_cur, 32'h0);

      // Reset while a fetch is outstanding.
      lat_min = 3; lat_max = 3;
      for (int k = 0; k < 10 && !mdl_outst; k++) step(1'b0, '0, 1'b1, 1'b1);
      do_reset();
      step(1'b0, '0, 1'b1, 1'b1);
      check("boot_pc", pc_cur, RV);

      // Randomized traffic.
      lat_min = 1; lat_max = 4;
      fires0 = fire_pc.size();
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(299, 0) == 0) begin
            do_reset();
         end else begin
            rv = !mdl_boot && ($urandom_range(11, 0) == 0);
            rt = $urandom_range(1, 0) ? 32'($urandom) : 32'($urandom_range(255, 0));
            step(rv, rt, $urandom_range(2, 0) != 0, $urandom_range(3, 0) != 0);
         end
      end
      check("rand_progress", fire_pc.size() - fires0 > 100, 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
